// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite response codes and FSM state encodings.
// Imported by the register slave and by the bus block.
package axi_lite_pkg;

    localparam logic RESP_OKAY   = 1'b0;
    localparam logic RESP_SLVERR = 1'b1;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

endpackage

// File: rtl/axi_lite_reg_slave_if.sv
// AXI4-Lite channel bundle between a master and the register slave.
// Ports: AW/W/B write channels and AR/R read channels; clock/reset stay outside.
interface axi_lite_reg_slave_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) ();

    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic                    bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    rresp;
    logic                    rvalid;
    logic                    rready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arvalid, rready,
        output awready, wready, bresp, bvalid,
        output arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid,
        input  arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/axi_lite_reg_array.sv
// NUM_REGS x DATA_WIDTH register storage, reset to zero.
// Ports: strobed write (we_i/widx_i/wdata_i/wstrb_i), combinational read (ridx_i/rdata_o).
module axi_lite_reg_array #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 8,
    parameter int IDX_W      = 6
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    we_i,
    input  logic [IDX_W-1:0]        widx_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] wstrb_i,
    input  logic [IDX_W-1:0]        ridx_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);

    localparam int STRB_W = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (widx_i == i[IDX_W-1:0]) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (wstrb_i[b]) begin
                            regs_q[i][8*b +: 8] <= wdata_i[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // Out-of-range indices read as zero.
    always_comb begin
        rdata_o = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ridx_i == i[IDX_W-1:0]) begin
                rdata_o = regs_q[i];
            end
        end
    end

endmodule

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite register bank slave with independent write and read FSMs.
// Ports: s0_axi_aclk, s0_axi_aresetn (async active-low), s0_axi slave modport.
module axi_lite_reg_slave
    import axi_lite_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_REGS   = 8
) (
    input  logic                 s0_axi_aclk,
    input  logic                 s0_axi_aresetn,
    axi_lite_reg_slave_if.slave  s0_axi
);

    localparam int IDX_W  = ADDR_WIDTH - 2;
    localparam int STRB_W = DATA_WIDTH / 8;

    function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] a);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (a[ADDR_WIDTH-1:2] == i[IDX_W-1:0]) begin
                hit = 1'b1;
            end
        end
        return (a[1:0] != 2'b00) || !hit;
    endfunction

    // Write channel state
    wr_state_e             wstate_q, wstate_d;
    logic                  aw_held_q, aw_held_d;
    logic                  w_held_q, w_held_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    logic                  bresp_q, bresp_d;

    // Read channel state
    rd_state_e             rstate_q, rstate_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rresp_q, rresp_d;

    logic                  awready, wready, bvalid;
    logic                  arready, rvalid;
    logic                  aw_hs, w_hs, ar_hs;
    logic                  aw_now, w_now;
    logic [ADDR_WIDTH-1:0] cur_awaddr;
    logic [DATA_WIDTH-1:0] cur_wdata;
    logic [STRB_W-1:0]     cur_wstrb;
    logic                  werr, rerr, commit, we;
    logic [DATA_WIDTH-1:0] arr_rdata;

    // A channel counts as present if captured earlier or handshaking now,
    // so AW and W can meet on the same edge or in either order.
    assign aw_hs      = s0_axi.awvalid && awready;
    assign w_hs       = s0_axi.wvalid && wready;
    assign ar_hs      = s0_axi.arvalid && arready;
    assign aw_now     = aw_held_q || aw_hs;
    assign w_now      = w_held_q || w_hs;
    assign cur_awaddr = aw_held_q ? awaddr_q : s0_axi.awaddr;
    assign cur_wdata  = w_held_q ? wdata_q : s0_axi.wdata;
    assign cur_wstrb  = w_held_q ? wstrb_q : s0_axi.wstrb;
    assign werr       = addr_err(cur_awaddr);
    assign rerr       = addr_err(s0_axi.araddr);
    assign commit     = (wstate_q == W_IDLE) && aw_now && w_now;
    assign we         = commit && !werr;

    axi_lite_reg_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .IDX_W      (IDX_W)
    ) u_regs (
        .clk_i   (s0_axi_aclk),
        .rst_ni  (s0_axi_aresetn),
        .we_i    (we),
        .widx_i  (cur_awaddr[ADDR_WIDTH-1:2]),
        .wdata_i (cur_wdata),
        .wstrb_i (cur_wstrb),
        .ridx_i  (s0_axi.araddr[ADDR_WIDTH-1:2]),
        .rdata_o (arr_rdata)
    );

    always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
        if (!s0_axi_aresetn) begin
            wstate_q  <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= RESP_OKAY;
            rstate_q  <= R_IDLE;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            wstate_q  <= wstate_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bresp_q   <= bresp_d;
            rstate_q  <= rstate_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    always_comb begin
        wstate_d  = wstate_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bresp_d   = bresp_q;
        unique case (wstate_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_held_d = 1'b1;
                    awaddr_d  = s0_axi.awaddr;
                end
                if (w_hs) begin
                    w_held_d = 1'b1;
                    wdata_d  = s0_axi.wdata;
                    wstrb_d  = s0_axi.wstrb;
                end
                if (commit) begin
                    wstate_d  = W_RESP;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    bresp_d   = werr ? RESP_SLVERR : RESP_OKAY;
                end
            end
            W_RESP: begin
                if (s0_axi.bready) begin
                    wstate_d = W_IDLE;
                end
            end
        endcase
    end

    // Read data is sampled from the array before this edge's write lands,
    // so a colliding read returns the old value.
    always_comb begin
        rstate_d = rstate_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        unique case (rstate_q)
            R_IDLE: begin
                if (ar_hs) begin
                    rstate_d = R_DATA;
                    rdata_d  = rerr ? '0 : arr_rdata;
                    rresp_d  = rerr ? RESP_SLVERR : RESP_OKAY;
                end
            end
            R_DATA: begin
                if (s0_axi.rready) begin
                    rstate_d = R_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        awready = (wstate_q == W_IDLE) && !aw_held_q;
        wready  = (wstate_q == W_IDLE) && !w_held_q;
        bvalid  = (wstate_q == W_RESP);
        arready = (rstate_q == R_IDLE);
        rvalid  = (rstate_q == R_DATA);
    end

    assign s0_axi.awready = awready;
    assign s0_axi.wready  = wready;
    assign s0_axi.bvalid  = bvalid;
    assign s0_axi.bresp   = bresp_q;
    assign s0_axi.arready = arready;
    assign s0_axi.rvalid  = rvalid;
    assign s0_axi.rdata   = rdata_q;
    assign s0_axi.rresp   = rresp_q;

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Directed bench for the AXI4-Lite register slave.
// Drives and samples on the falling clock edge.
module tb_axi_lite_reg_slave;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    axi_lite_reg_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) intf ();

    axi_lite_reg_slave #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (8),
        .NUM_REGS   (8)
    ) dut (
        .s0_axi_aclk    (clk),
        .s0_axi_aresetn (rst_n),
        .s0_axi         (intf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic resp);
        bit aw_ok, w_ok, b_ok, done;
        done = 1'b0;
        resp = 1'bx;
        intf.awaddr  = a;
        intf.awvalid = 1'b1;
        intf.wdata   = d;
        intf.wstrb   = s;
        intf.wvalid  = 1'b1;
        intf.bready  = 1'b1;
        for (int n = 0; n < 20 && !done; n++) begin
            aw_ok = intf.awvalid && intf.awready;
            w_ok  = intf.wvalid && intf.wready;
            b_ok  = intf.bvalid;
            if (b_ok) resp = intf.bresp;
            @(negedge clk);
            if (aw_ok) intf.awvalid = 1'b0;
            if (w_ok)  intf.wvalid  = 1'b0;
            if (b_ok)  done = 1'b1;
        end
        intf.awvalid = 1'b0;
        intf.wvalid  = 1'b0;
        chk("wr_done", {31'd0, done}, 32'd1);
    endtask

    task automatic do_read(input logic [7:0] a, output logic [31:0] d,
                           output logic resp);
        bit a_ok, r_ok, done;
        done = 1'b0;
        d = 'x;
        resp = 1'bx;
        intf.araddr  = a;
        intf.arvalid = 1'b1;
        intf.rready  = 1'b1;
        for (int n = 0; n < 20 && !done; n++) begin
            a_ok = intf.arvalid && intf.arready;
            r_ok = intf.rvalid;
            if (r_ok) begin
                d    = intf.rdata;
                resp = intf.rresp;
            end
            @(negedge clk);
            if (a_ok) intf.arvalid = 1'b0;
            if (r_ok) done = 1'b1;
        end
        intf.arvalid = 1'b0;
        chk("rd_done", {31'd0, done}, 32'd1);
    endtask

    logic        br;
    logic        rr;
    logic [31:0] rd;

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        intf.awaddr  = '0;
        intf.awvalid = 1'b0;
        intf.wdata   = '0;
        intf.wstrb   = '0;
        intf.wvalid  = 1'b0;
        intf.bready  = 1'b0;
        intf.araddr  = '0;
        intf.arvalid = 1'b0;
        intf.rready  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state: {awready,wready,arready,bvalid,rvalid,bresp,rresp}
        chk("rst_flags", {25'd0, intf.awready, intf.wready, intf.arready,
            intf.bvalid, intf.rvalid, intf.bresp, intf.rresp}, 32'h70);
        chk("rst_rdata", intf.rdata, 32'h0);

        // Same-cycle AW+W, bvalid exactly one cycle later
        intf.awaddr  = 8'h00;
        intf.wdata   = 32'h17;
        intf.wstrb   = 4'hF;
        intf.awvalid = 1'b1;
        intf.wvalid  = 1'b1;
        intf.bready  = 1'b0;
        @(negedge clk);
        intf.awvalid = 1'b0;
        intf.wvalid  = 1'b0;
        chk("t1_bvalid", {31'd0, intf.bvalid}, 32'd1);
        chk("t1_bresp", {31'd0, intf.bresp}, 32'd0);
        intf.bready = 1'b1;
        @(negedge clk);
        chk("t1_bdone", {30'd0, intf.bvalid, intf.awready}, 32'd1);
        do_read(8'h00, rd, rr);
        chk("t1_rdata", rd, 32'h17);
        chk("t1_rresp", {31'd0, rr}, 32'd0);

        // W three cycles ahead of AW
        intf.bready = 1'b1;
        intf.wdata  = 32'h1E;
        intf.wstrb  = 4'hF;
        intf.wvalid = 1'b1;
        @(negedge clk);
        intf.wvalid = 1'b0;
        chk("t2_w_held", {30'd0, intf.wready, intf.bvalid}, 32'd0);
        repeat (2) @(negedge clk);
        chk("t2_no_commit", {31'd0, intf.bvalid}, 32'd0);
        intf.awaddr  = 8'h04;
        intf.awvalid = 1'b1;
        @(negedge clk);
        intf.awvalid = 1'b0;
        chk("t2_bvalid", {31'd0, intf.bvalid}, 32'd1);
        @(negedge clk);
        do_read(8'h04, rd, rr);
        chk("t2_rdata", rd, 32'h1E);

        // Byte strobes
        do_write(8'h10, 32'hAABBCCDD, 4'hF, br);
        do_write(8'h10, 32'h11223344, 4'h5, br);
        chk("t3_bresp", {31'd0, br}, 32'd0);
        do_read(8'h10, rd, rr);
        chk("t3_rdata", rd, 32'hAA22CC44);

        // Error writes and reads
        do_write(8'h20, 32'hDEADBEEF, 4'hF, br);
        chk("t4_bresp_oob", {31'd0, br}, 32'd1);
        do_write(8'h02, 32'hDEADBEEF, 4'hF, br);
        chk("t4_bresp_mis", {31'd0, br}, 32'd1);
        do_read(8'h00, rd, rr);
        chk("t4_reg0_kept", rd, 32'h17);
        do_read(8'h20, rd, rr);
        chk("t4_rd_oob", {rd[30:0], rr}, 32'd1);
        do_read(8'h02, rd, rr);
        chk("t4_rd_mis", {rd[30:0], rr}, 32'd1);
        do_read(8'h1C, rd, rr);
        chk("t4_rd_last", {rd[30:0], rr}, 32'd0);

        // Back-pressure on B and R
        intf.bready  = 1'b0;
        intf.awaddr  = 8'h18;
        intf.wdata   = 32'h5A5A;
        intf.wstrb   = 4'hF;
        intf.awvalid = 1'b1;
        intf.wvalid  = 1'b1;
        @(negedge clk);
        intf.awvalid = 1'b0;
        intf.wvalid  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t5_bhold", {28'd0, intf.bvalid, intf.bresp,
                intf.awready, intf.wready}, 32'h8);
            @(negedge clk);
        end
        intf.bready = 1'b1;
        @(negedge clk);
        chk("t5_brel", {30'd0, intf.bvalid, intf.awready}, 32'd1);
        intf.rready  = 1'b0;
        intf.araddr  = 8'h18;
        intf.arvalid = 1'b1;
        @(negedge clk);
        intf.arvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t5_rhold", {intf.rdata[29:0], intf.rvalid,
                intf.arready}, {30'h5A5A, 2'b10});
            @(negedge clk);
        end
        intf.rready = 1'b1;
        @(negedge clk);
        chk("t5_rrel", {30'd0, intf.rvalid, intf.arready}, 32'd1);

        // Read/write collision on the same edge
        intf.bready  = 1'b0;
        intf.rready  = 1'b0;
        intf.awaddr  = 8'h14;
        intf.wdata   = 32'h25;
        intf.wstrb   = 4'hF;
        intf.araddr  = 8'h14;
        intf.awvalid = 1'b1;
        intf.wvalid  = 1'b1;
        intf.arvalid = 1'b1;
        @(negedge clk);
        intf.awvalid = 1'b0;
        intf.wvalid  = 1'b0;
        intf.arvalid = 1'b0;
        chk("t6_both_valid", {30'd0, intf.bvalid, intf.rvalid}, 32'd3);
        chk("t6_old_data", intf.rdata, 32'h0);
        intf.bready = 1'b1;
        intf.rready = 1'b1;
        @(negedge clk);
        do_read(8'h14, rd, rr);
        chk("t6_new_data", rd, 32'h25);

        // Reset while in W_RESP
        intf.bready  = 1'b0;
        intf.awaddr  = 8'h0C;
        intf.wdata   = 32'h99;
        intf.awvalid = 1'b1;
        intf.wvalid  = 1'b1;
        @(negedge clk);
        intf.awvalid = 1'b0;
        intf.wvalid  = 1'b0;
        chk("t7_in_resp", {31'd0, intf.bvalid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t7_async_rst", {30'd0, intf.bvalid, intf.awready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        intf.bready = 1'b1;
        @(negedge clk);
        do_read(8'h14, rd, rr);
        chk("t7_regs_clear", rd, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_lite_reg_slave.md
Name: axi_lite_reg_slave

Overview:
AXI4-Lite slave register bank that terminates the m1 master port of the bus block. It decodes byte addresses into a small array of DATA_WIDTH-bit registers and applies byte strobes on writes. Write and read channels are served by independent FSMs. It is the downstream consumer of every transaction the bus forwards.

Parameters:
DATA_WIDTH, 32, data bus width in bits; must be a multiple of 8.
ADDR_WIDTH, 8, byte address width.
NUM_REGS, 8, number of word registers; must be ≤ 2^(ADDR_WIDTH-2).

Ports:
s0_axi_aclk  in  1  single clock.
s0_axi_aresetn  in  1  asynchronous active-low reset.
s0_axi_awaddr  in  ADDR_WIDTH  write byte address.
s0_axi_awvalid  in  1  write address valid.
s0_axi_awready  out  1  write address ready.
s0_axi_wdata  in  DATA_WIDTH  write data.
s0_axi_wstrb  in  DATA_WIDTH/8  byte enables; bit i covers wdata[8i+7:8i].
s0_axi_wvalid  in  1  write data valid.
s0_axi_wready  out  1  write data ready.
s0_axi_bresp  out  1  write response: 0=OKAY, 1=SLVERR.
s0_axi_bvalid  out  1  write response valid.
s0_axi_bready  in  1  write response ready.
s0_axi_araddr  in  ADDR_WIDTH  read byte address.
s0_axi_arvalid  in  1  read address valid.
s0_axi_arready  out  1  read address ready.
s0_axi_rdata  out  DATA_WIDTH  read data.
s0_axi_rresp  out  1  read response: 0=OKAY, 1=SLVERR.
s0_axi_rvalid  out  1  read data valid.
s0_axi_rready  in  1  read data ready.

Behaviour:
- Reset (async assert, sync release): all registers 0; awready=1, wready=1, arready=1; bvalid=0, bresp=0, rvalid=0, rresp=0, rdata=0; both FSMs to idle. Reset mid-transaction abandons it; no partial write commits.
- Decode: index = addr[ADDR_WIDTH-1:2]. Error when addr[1:0]!=0 or index ≥ NUM_REGS.
- Write FSM states: W_IDLE, W_RESP.
  - W_IDLE: awready=1 until AW is captured, then 0; wready=1 until W is captured, then 0. AW and W may arrive in either order or on the same edge; each is latched independently on its handshake.
  - On the edge where both are held (captured now or earlier): commit the write (per-strobe byte merge; strobe 0 writes nothing), set bresp, bvalid=1, go to W_RESP. Same-cycle AW+W gives bvalid in the next cycle.
  - Error write: no register changes, bresp=1.
  - W_RESP: bvalid held, bresp stable until bready. On bvalid&&bready: bvalid=0, awready=wready=1, back to W_IDLE. Back-to-back writes: one write per 2 cycles with bready tied high.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: arready=1. On arvalid: sample the register into rdata (0 on error), rresp, rvalid=1, arready=0, go to R_DATA.
  - R_DATA: rdata, rresp, rvalid held stable until rready. On handshake: rvalid=0, arready=1, back to R_IDLE.
- Read/write collision: a read handshake on the same edge as a write commit to the same index returns the pre-write value. A read in any later cycle sees the new value.
- Read and write FSMs run fully concurrently; neither stalls the other.
- Valid-driven outputs never drop before their handshake completes.

Decomposition:
- Package axi_lite_pkg: RESP_OKAY=1'b0, RESP_SLVERR=1'b1, write/read FSM state encodings, shared with the bus block.
- Sub-module axi_lite_reg_array: NUM_REGS×DATA_WIDTH storage with strobed write port and one combinational read port, reset to 0. The top level holds both FSMs and the decode.

Test Plan:
- Reset, then write 0x17 at addr 0x00 with wstrb=0xF and AW/W on the same cycle → bvalid one cycle later, bresp=0. Read 0x00 → rdata=0x17, rresp=0.
- Write 0x1E at 0x04, then send W 3 cycles before AW → commit only after AW arrives, bvalid the cycle after. Read 0x04 → 0x1E.
- Preload 0xAABBCCDD at 0x10; write 0x11223344 with wstrb=0x5 → read 0x10 gives 0xAA22CC44.
- Write to 0x20 (index 8) and to 0x02 → bresp=1 and no register changes. Reads of 0x20 and 0x02 → rdata=0, rresp=1.
- Hold bready=0 for 4 cycles and rready=0 for 4 cycles → bvalid/bresp and rvalid/rdata stay stable. awready and arready stay 0 until the handshake completes.
- Read 0x14 on the same edge as a write commit of 0x25 to 0x14 (old 0x0) → rdata=0x0; next read → 0x25. Assert reset during W_RESP → bvalid=0 and awready=1 immediately.
